// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types and constants for the memory stage
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam regbits_t DEFAULT_JAL_REG = 5'd31;

endpackage

// File: rtl/link_reg.sv
// rtl/link_reg.sv - LL/SC reservation register with snoop invalidation
module link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  ll_set,
    input  logic  sc_done,
    input  logic  store_done,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    input  word_t addr,
    output logic  sc_ok
);

    logic  valid_q, valid_d;
    word_t addr_q, addr_d;

    // A completing LL takes priority over every clearing source on the same edge
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (ll_set) begin
            valid_d = 1'b1;
            addr_d  = addr;
        end else if ((snoop_inv && (snoop_addr == addr_q)) || sc_done ||
                     (store_done && (addr == addr_q))) begin
            valid_d = 1'b0;
        end
    end

    // Reservation state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    // An SC may only write while the reservation still covers its address
    always_comb begin
        sc_ok = valid_q && (addr_q == addr);
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access stage and MEM/WB pipeline latch
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter regbits_t JAL_REG   = DEFAULT_JAL_REG,
    parameter int       WAITCNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          aluOutport_in,
    input  logic [31:0]          rdat2_in,
    input  logic [31:0]          pcplus4_in,
    input  logic [4:0]           rt_in,
    input  logic [4:0]           rd_in,
    input  logic                 RegDst_in,
    input  logic                 MemToReg_in,
    input  logic                 regWEN_in,
    input  logic                 JType_in,
    input  logic                 Halt_in,
    input  logic                 dMemREN_in,
    input  logic                 dMemWEN_in,
    input  logic                 ll_in,
    input  logic                 sc_in,
    input  logic                 flush,
    input  logic                 dhit,
    input  logic [31:0]          dmemload,
    input  logic                 snoop_inv,
    input  logic [31:0]          snoop_addr,
    output logic                 dmemREN,
    output logic                 dmemWEN,
    output logic [31:0]          dmemaddr,
    output logic [31:0]          dmemstore,
    output logic                 mem_stall,
    output logic [4:0]           wsel_out,
    output logic [31:0]          wdat_out,
    output logic                 wen_out,
    output logic                 halt_out,
    output logic [WAITCNT_W-1:0] waitcnt_out
);

    mem_state_t           state_q, state_d;
    regbits_t             wsel_q, wsel_d, wb_sel;
    word_t                wdat_q, wdat_d, wb_dat;
    logic                 wen_q, wen_d;
    logic                 halt_q, halt_d;
    logic [WAITCNT_W-1:0] waitcnt_q, waitcnt_d;
    logic                 sc_ok;
    logic                 req_ren, req_wen;

    link_reg u_link_reg (
        .CLK        (CLK),
        .RST        (RST),
        .ll_set     (ll_in && req_ren && dhit),
        .sc_done    (sc_in && dMemWEN_in && !halt_q && !mem_stall),
        .store_done (req_wen && dhit),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .addr       (aluOutport_in),
        .sc_ok      (sc_ok)
    );

    // Access state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter ACCESS only for an issued request that did not hit in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((req_ren || req_wen) && !dhit) state_d = ACCESS;
            ACCESS:  if (dhit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request issue and stall; a halted core or failing SC issues nothing
    always_comb begin
        req_ren   = dMemREN_in && !halt_q;
        req_wen   = dMemWEN_in && !halt_q && !(sc_in && !sc_ok);
        mem_stall = (req_ren || req_wen) && !dhit;
        dmemREN   = req_ren;
        dmemWEN   = req_wen;
        dmemaddr  = aluOutport_in;
        dmemstore = rdat2_in;
    end

    // Writeback register / data selection
    always_comb begin
        wb_sel = JType_in ? JAL_REG : (RegDst_in ? rd_in : rt_in);
        if (JType_in)         wb_dat = pcplus4_in;
        else if (sc_in)       wb_dat = {31'b0, sc_ok};
        else if (MemToReg_in) wb_dat = dmemload;
        else                  wb_dat = aluOutport_in;
    end

    // MEM/WB latch next value: hold on stall, bubble on flush, else load
    always_comb begin
        wsel_d    = wsel_q;
        wdat_d    = wdat_q;
        wen_d     = wen_q;
        halt_d    = halt_q;
        waitcnt_d = waitcnt_q;
        if (mem_stall && (waitcnt_q != {WAITCNT_W{1'b1}})) begin
            waitcnt_d = waitcnt_q + 1'b1;
        end
        if (!mem_stall) begin
            if (flush) begin
                wsel_d = '0;
                wdat_d = '0;
                wen_d  = 1'b0;
            end else begin
                wsel_d = wb_sel;
                wdat_d = wb_dat;
                wen_d  = regWEN_in && !halt_q;
                halt_d = halt_q || Halt_in;
            end
        end
    end

    // MEM/WB latch and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            wsel_q    <= '0;
            wdat_q    <= '0;
            wen_q     <= 1'b0;
            halt_q    <= 1'b0;
            waitcnt_q <= '0;
        end else begin
            wsel_q    <= wsel_d;
            wdat_q    <= wdat_d;
            wen_q     <= wen_d;
            halt_q    <= halt_d;
            waitcnt_q <= waitcnt_d;
        end
    end

    assign wsel_out    = wsel_q;
    assign wdat_out    = wdat_q;
    assign wen_out     = wen_q;
    assign halt_out    = halt_q;
    assign waitcnt_out = waitcnt_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline latch of the 5-stage MIPS datapath. Sits directly downstream of the EX/MEM latch and consumes its outputs.
- Issues the data-memory request and holds the pipeline (mem_stall) until dhit.
- Resolves LL/SC through a link register, selects the writeback register and data, and registers the result for the WB stage and register file.

Parameters:
JAL_REG, 5'd31, destination register for JType (jal) writeback
WAITCNT_W, 16, width of the saturating memory-wait performance counter

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  synchronous, active-high reset
aluOutport_in  in  32  effective address / ALU result from EX/MEM
rdat2_in  in  32  store data from EX/MEM
pcplus4_in  in  32  return address for jal
rt_in, rd_in  in  5 each  candidate destination registers
RegDst_in, MemToReg_in, regWEN_in, JType_in, Halt_in  in  1 each  control from EX/MEM
dMemREN_in, dMemWEN_in  in  1 each  load/store request from EX/MEM
ll_in, sc_in  in  1 each  instruction is LL / SC (qualify dMemREN_in / dMemWEN_in)
flush  in  1  insert bubble into MEM/WB on the next edge
dhit  in  1  data memory acknowledge
dmemload  in  32  load data, valid when dhit
snoop_inv  in  1  coherence invalidation strobe
snoop_addr  in  32  invalidated address
dmemREN, dmemWEN  out  1 each  data memory request
dmemaddr, dmemstore  out  32 each  request address / store data
mem_stall  out  1  to hazard unit: freeze PC, IF/ID, ID/EX, EX/MEM
wsel_out  out  5  registered writeback register
wdat_out  out  32  registered writeback data
wen_out  out  1  registered register-file write enable
halt_out  out  1  registered, sticky halt
waitcnt_out  out  WAITCNT_W  total cycles spent stalled on memory

Behaviour:
- Reset (RST=1 at edge):
  - wsel_out=0, wdat_out=0, wen_out=0, halt_out=0, waitcnt_out=0.
  - Link register: valid=0, addr=0. FSM=IDLE.
  - Overrides flush and all other inputs.
- FSM states:
  - IDLE: no access pending.
  - ACCESS: waiting for dhit.
  - IDLE->ACCESS: (dMemREN_in|dMemWEN_in) & ~dhit & ~halt_out.
  - ACCESS->IDLE: on dhit.
  - A same-cycle dhit completes in IDLE with no ACCESS visit.
- Request outputs (combinational):
  - dmemaddr=aluOutport_in, dmemstore=rdat2_in.
  - dmemREN = dMemREN_in & ~halt_out.
  - dmemWEN = dMemWEN_in & ~halt_out & ~(sc_in & ~sc_ok).
  - sc_ok = link.valid & (link.addr == aluOutport_in).
  - A failing SC issues no memory write and completes immediately with no stall.
- mem_stall = (dmemREN|dmemWEN) & ~dhit. Requests stay asserted and stable while stalled.
- MEM/WB latch:
  - Holds its value while mem_stall=1.
  - Otherwise loads on each edge; if flush, loads a bubble (wen=0, wsel=0, wdat=0).
- Writeback selection:
  - wsel = JType_in ? JAL_REG : (RegDst_in ? rd_in : rt_in).
  - wdat priority: JType → pcplus4_in; sc_in → {31'b0, sc_ok}; MemToReg → dmemload; else aluOutport_in.
  - wen = regWEN_in.
- Latency: one edge after request completion (or immediately for non-memory ops).
- Link register:
  - LL completing (dhit): valid=1, addr=aluOutport_in.
  - Any SC completing clears valid.
  - snoop_inv with snoop_addr==link.addr clears valid.
  - Snoop-clear and LL-set on the same edge: LL wins.
  - A store from this core to link.addr clears valid.
- halt_out:
  - Set when Halt_in is latched without a bubble. Sticky until RST.
  - Once set, all further memory requests are suppressed, mem_stall=0, and wen_out is forced 0 for later entries.
- waitcnt_out: +1 every cycle mem_stall=1; saturates at all-ones.
- Memory stall has priority over flush: flush is ignored while mem_stall=1. The hazard unit re-presents flush.

Decomposition:
- cpu_types_pkg supplies word_t, regbits_t, plus two new package items:
  - typedef mem_state_t {IDLE, ACCESS}
  - constant JAL_REG default
- Natural sub-module: link_reg (LL/SC reservation: set/clear/snoop compare, sc_ok output).

Test Plan:
1. Load, dhit delayed 3 cycles, dmemload=0xDEADBEEF, MemToReg=1, rt=8, RegDst=0 → mem_stall=1 for 3 cycles, latch frozen; next edge: wsel_out=8, wdat_out=0xDEADBEEF, wen_out=1, waitcnt_out=3.
2. jal (JType=1, pcplus4=0x0000_0104, regWEN=1) with flush=0 → wsel_out=31, wdat_out=0x104 one edge later, no memory request.
3. LL at 0x100, then SC at 0x100 with store data 5 → dmemWEN=1 and wdat_out=1. Second SC at 0x100 → dmemWEN=0, wdat_out=0, mem_stall=0.
4. LL at 0x200, snoop_inv with snoop_addr=0x200, then SC at 0x200 → SC fails with wdat_out=0. Repeat with snoop_addr=0x204 → SC succeeds.
5. Halt_in=1 latched, then a store presented → halt_out=1 stays high, dmemWEN=0, mem_stall=0. RST → halt_out=0.
6. flush asserted while mem_stall=1 → latch unchanged. Flush held after dhit → wen_out=0. RST during ACCESS → FSM IDLE, all outputs 0 next cycle.
